// File: rtl/led_pattern_engine_if.sv
// Controller-side bundle for the LED pattern engine: mode requests, bar level,
// and the LED/mode/step outputs.
interface led_pattern_engine_if #(
  parameter int LED_W = 4
);
  localparam int LVL_W = $clog2(LED_W + 1);

  logic [3:0]       req;
  logic [LVL_W-1:0] level;
  logic [LED_W-1:0] led;
  logic [2:0]       mode_o;
  logic             step_o;

  modport master (output req, output level, input led, input mode_o, input step_o);
  modport slave  (input req, input level, output led, output mode_o, output step_o);
endinterface

// File: rtl/led_pattern_engine.sv
// LED pattern generator/arbiter: off, bounce sweep, bar, flash and PWM pulse
// modes selected by a priority request vector, with a blank gap on mode switch.
module led_pattern_engine #(
  parameter int LED_W      = 4,
  parameter int TICK_DIV   = 12500000,
  parameter int PULSE_DIV  = 48828,
  parameter int PWM_BITS   = 8,
  parameter int GAP_TICKS  = 1,
  parameter int ACTIVE_LOW = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  led_pattern_engine_if.slave   bus
);
  localparam int LVL_W = $clog2(LED_W + 1);
  localparam int TW    = $clog2(TICK_DIV);
  localparam int PW    = $clog2(LED_W);
  localparam int DIV_W = (PULSE_DIV > 1) ? $clog2(PULSE_DIV) : 1;
  localparam int GAP_W = (GAP_TICKS > 0) ? $clog2(GAP_TICKS + 1) : 1;
  localparam logic [LED_W-1:0] POL = (ACTIVE_LOW != 0) ? '1 : '0;

  typedef enum logic [2:0] {
    MODE_OFF   = 3'd0,
    MODE_SWEEP = 3'd1,
    MODE_BAR   = 3'd2,
    MODE_FLASH = 3'd3,
    MODE_PULSE = 3'd4
  } mode_t;

  mode_t               mode, mode_next, sel;
  logic [TW-1:0]       tick_cnt;
  logic                tick;
  logic                step_q;
  logic [GAP_W-1:0]    gap;
  logic                change;
  logic [PW-1:0]       pos;
  logic                dir_up;
  logic                phase;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [PWM_BITS-1:0] duty;
  logic                duty_up;
  logic [DIV_W-1:0]    div_cnt;
  logic [LVL_W-1:0]    level_q;
  logic [LED_W-1:0]    bar;
  logic [LED_W-1:0]    pattern;
  logic [LED_W-1:0]    led_q;

  assign tick   = (tick_cnt == TW'(TICK_DIV - 1));
  assign change = (sel != mode);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_cnt <= '0;
      step_q   <= 1'b0;
      level_q  <= '0;
    end else begin
      tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
      step_q   <= tick;
      level_q  <= bus.level;
    end
  end

  always_comb begin
    sel = MODE_OFF;
    if      (bus.req[0]) sel = MODE_FLASH;
    else if (bus.req[1]) sel = MODE_PULSE;
    else if (bus.req[2]) sel = MODE_BAR;
    else if (bus.req[3]) sel = MODE_SWEEP;
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) mode <= MODE_OFF;
    else     mode <= mode_next;
  end

  // Next-state logic
  always_comb begin
    mode_next = sel;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)              gap <= '0;
    else if (change)      gap <= GAP_W'(GAP_TICKS);
    else if (gap != '0 && tick) gap <= gap - 1'b1;
  end

  // Pattern state; a mode change in a tick cycle re-initialises instead of advancing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pos     <= '0;
      dir_up  <= 1'b1;
      phase   <= 1'b1;
      pwm_cnt <= '0;
      duty    <= '0;
      duty_up <= 1'b1;
      div_cnt <= '0;
    end else if (change) begin
      pos     <= '0;
      dir_up  <= 1'b1;
      phase   <= 1'b1;
      pwm_cnt <= '0;
      duty    <= '0;
      duty_up <= 1'b1;
      div_cnt <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + 1'b1;
      if (gap == '0) begin
        if (tick) begin
          phase <= ~phase;
          if (dir_up) begin
            if (pos == PW'(LED_W - 1)) begin
              dir_up <= 1'b0;
              pos    <= pos - 1'b1;
            end else begin
              pos <= pos + 1'b1;
            end
          end else begin
            if (pos == '0) begin
              dir_up <= 1'b1;
              pos    <= pos + 1'b1;
            end else begin
              pos <= pos - 1'b1;
            end
          end
        end
        if (div_cnt == DIV_W'(PULSE_DIV - 1)) begin
          div_cnt <= '0;
          if (duty_up) begin
            if (duty == '1) begin
              duty_up <= 1'b0;
              duty    <= duty - 1'b1;
            end else begin
              duty <= duty + 1'b1;
            end
          end else begin
            if (duty == '0) begin
              duty_up <= 1'b1;
              duty    <= duty + 1'b1;
            end else begin
              duty <= duty - 1'b1;
            end
          end
        end else begin
          div_cnt <= div_cnt + 1'b1;
        end
      end
    end
  end

  always_comb begin
    bar = '0;
    for (int unsigned i = 0; i < LED_W; i++) begin
      bar[i] = (32'(level_q) > i);
    end
  end

  // Output logic
  always_comb begin
    pattern = '0;
    if (gap == '0) begin
      case (mode)
        MODE_SWEEP: pattern = LED_W'(1) << pos;
        MODE_BAR:   pattern = bar;
        MODE_FLASH: pattern = {LED_W{phase}};
        MODE_PULSE: pattern = {LED_W{pwm_cnt < duty}};
        default:    pattern = '0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) led_q <= POL;
    else     led_q <= pattern ^ POL;
  end

  assign bus.led    = led_q;
  assign bus.mode_o = mode;
  assign bus.step_o = step_q;
endmodule

// File: tb/tb_led_pattern_engine.sv
// Directed bench for led_pattern_engine: sweep/reset, priority/gap reload,
// flash, pulse ramp, bar levels and active-low polarity.
module tb_led_pattern_engine;
  logic clk = 1'b0;
  logic rst;
  int n_checks = 0;
  int n_errors = 0;

  led_pattern_engine_if #(.LED_W(4)) bus_a ();
  led_pattern_engine_if #(.LED_W(4)) bus_b ();

  led_pattern_engine #(
    .LED_W(4), .TICK_DIV(4), .PULSE_DIV(2), .PWM_BITS(3), .GAP_TICKS(1), .ACTIVE_LOW(0)
  ) dut_a (
    .clk(clk), .rst(rst), .bus(bus_a)
  );

  led_pattern_engine #(
    .LED_W(4), .TICK_DIV(4), .PULSE_DIV(2), .PWM_BITS(3), .GAP_TICKS(1), .ACTIVE_LOW(1)
  ) dut_b (
    .clk(clk), .rst(rst), .bus(bus_b)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  logic [3:0] sweep_exp [7] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001};
  logic [3:0] bar_exp   [6] = '{4'b0000, 4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1111};
  logic [0:21] pulse_exp = 22'b0000000011111000111110;

  initial begin
    rst = 1'b1;
    bus_a.req = 4'b0000; bus_a.level = '0;
    bus_b.req = 4'b0000; bus_b.level = '0;
    step(2);
    check("rst_led", 32'(bus_a.led), 32'h0);
    check("rst_mode", 32'(bus_a.mode_o), 32'd0);
    check("rst_step", 32'(bus_a.step_o), 32'd0);
    check("rst_led_al", 32'(bus_b.led), 32'hF);

    // Sweep from reset release; E1 is the next rising edge
    bus_a.req = 4'b1000;
    #1 rst = 1'b0;
    step(1);
    check("sweep_mode", 32'(bus_a.mode_o), 32'd1);
    check("sweep_led_e1", 32'(bus_a.led), 32'h0);
    step(3);
    check("sweep_gap", 32'(bus_a.led), 32'h0);
    check("step_hi", 32'(bus_a.step_o), 32'd1);
    step(1);
    check("sweep_0", 32'(bus_a.led), 32'(sweep_exp[0]));
    check("step_lo", 32'(bus_a.step_o), 32'd0);
    for (int i = 1; i < 7; i++) begin
      step(4);
      check("sweep_seq", 32'(bus_a.led), 32'(sweep_exp[i]));
    end

    // Asynchronous reset mid-sweep
    rst = 1'b1;
    #1;
    check("arst_led", 32'(bus_a.led), 32'h0);
    check("arst_mode", 32'(bus_a.mode_o), 32'd0);
    bus_a.req = 4'b1101;
    #1 rst = 1'b0;

    // Priority, flash, switch to pulse and gap reload with tick collision
    step(1);
    check("prio_flash", 32'(bus_a.mode_o), 32'd3);
    bus_a.req = 4'b1111;
    step(3);
    check("flash_gap", 32'(bus_a.led), 32'h0);
    step(1);
    check("flash_on", 32'(bus_a.led), 32'hF);
    bus_a.req = 4'b1110;
    step(1);
    check("prio_pulse", 32'(bus_a.mode_o), 32'd4);
    check("switch_led_lag", 32'(bus_a.led), 32'hF);
    step(1);
    check("switch_gap", 32'(bus_a.led), 32'h0);
    bus_a.req = 4'b1111;
    step(1);
    check("reload_mode", 32'(bus_a.mode_o), 32'd3);
    step(1);
    check("reload_gap", 32'(bus_a.led), 32'h0);
    step(3);
    check("reload_gap_end", 32'(bus_a.led), 32'h0);
    step(1);
    check("flash_start_on", 32'(bus_a.led), 32'hF);
    step(3);
    check("flash_step_hi", 32'(bus_a.step_o), 32'd1);
    step(1);
    check("flash_off", 32'(bus_a.led), 32'h0);
    check("flash_step_lo", 32'(bus_a.step_o), 32'd0);
    step(4);
    check("flash_on2", 32'(bus_a.led), 32'hF);

    // Pulse ramp: one check per clock across the 7 -> 6 turnaround
    bus_a.req = 4'b0010;
    step(1);
    check("pulse_mode", 32'(bus_a.mode_o), 32'd4);
    for (int k = 0; k < 22; k++) begin
      step(1);
      check($sformatf("pulse_%0d", k), 32'(bus_a.led), {28'h0, {4{pulse_exp[k]}}});
    end

    // Bar levels, two-clock latency from level to led
    bus_a.req = 4'b0100;
    bus_a.level = '0;
    step(1);
    check("bar_mode", 32'(bus_a.mode_o), 32'd2);
    step(3);
    check("bar_gap", 32'(bus_a.led), 32'h0);
    for (int i = 0; i < 6; i++) begin
      bus_a.level = 3'(i);
      step(2);
      check($sformatf("bar_%0d", i), 32'(bus_a.led), 32'(bar_exp[i]));
    end
    bus_a.level = 3'd2;
    step(1);
    check("bar_lat1", 32'(bus_a.led), 32'hF);
    step(1);
    check("bar_lat2", 32'(bus_a.led), 32'h3);

    check("al_off_led", 32'(bus_b.led), 32'hF);
    check("al_off_mode", 32'(bus_b.mode_o), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
